// File: rtl/bch_pkg.sv
// Shared types and constant-time GF(2^M) helpers for the serial BCH decoder.
package bch_pkg;

  typedef enum logic [2:0] {
    ST_RX    = 3'd0,
    ST_CUBE  = 3'd1,
    ST_INV   = 3'd2,
    ST_SIGMA = 3'd3,
    ST_CHIEN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Code length for a field of degree m.
  function automatic int bch_n(input int m);
    return (1 << m) - 1;
  endfunction

  // Elaboration-time field product (m <= 8), used to derive the alpha constants.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] b,
                                              input int m, input logic [8:0] poly);
    logic [8:0] sh;
    logic [7:0] acc;
    acc = 8'd0;
    sh  = {1'b0, a};
    for (int i = 0; i < m; i++) begin
      if (b[i]) acc = acc ^ sh[7:0];
      else      acc = acc;
      sh = {sh[7:0], 1'b0};
      if (sh[m]) sh = sh ^ poly;
      else       sh = sh;
    end
    return acc;
  endfunction

  // alpha^e, with alpha = x.
  function automatic logic [7:0] alpha_pow(input int e, input int m, input logic [8:0] poly);
    logic [7:0] r;
    r = 8'd1;
    for (int i = 0; i < e; i++) r = gf_mul_const(r, 8'd2, m, poly);
    return r;
  endfunction

endpackage

// File: rtl/bch_gf_mult.sv
// Combinational GF(2^M) multiplier: a*b reduced by PRIM_POLY.
module bch_gf_mult
  import bch_pkg::*;
#(
  parameter int         M         = 4,
  parameter logic [M:0] PRIM_POLY = 5'b10011
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);

  logic [M-1:0] acc;
  logic [M:0]   sh;

  // Shift-and-add product with reduction after every shift.
  always_comb begin
    acc = {M{1'b0}};
    sh  = {1'b0, a};
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh[M-1:0];
      else      acc = acc;
      sh = {sh[M-1:0], 1'b0};
      if (sh[M]) sh = sh ^ PRIM_POLY;
      else       sh = sh;
    end
    p = acc;
  end

endmodule

// File: rtl/bch_serial_decoder.sv
// Bit-serial t=2 BCH decoder: Horner syndromes, iterative inverse, Chien search.
module bch_serial_decoder
  import bch_pkg::*;
#(
  parameter int         M         = 4,
  parameter logic [M:0] PRIM_POLY = 5'b10011,
  parameter int         K         = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_msg,
  output logic [1:0]   out_err_cnt,
  output logic         out_fail
);

  localparam int           N          = bch_n(M);
  localparam int           CW         = $clog2(N + 1);
  localparam logic [8:0]   POLY9      = 9'(PRIM_POLY);
  localparam logic [M-1:0] ALPHA      = M'(alpha_pow(1, M, POLY9));
  localparam logic [M-1:0] ALPHA3     = M'(alpha_pow(3, M, POLY9));
  localparam logic [M-1:0] ALPHA_INV  = M'(alpha_pow(N - 1, M, POLY9));
  localparam logic [M-1:0] ALPHA_INV2 = M'(alpha_pow(N - 2, M, POLY9));
  localparam logic [M-1:0] GF_ONE     = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] GF_ZERO    = {M{1'b0}};
  localparam logic [N-1:0] N_ONE      = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [N-1:0]   buffer;
  logic [K-1:0]   raw_msg;
  logic [M-1:0]   s1, s3, c, acc, p, t1, t2;
  logic [CW-1:0]  bit_cnt;
  logic [M-1:0]   step;
  logic [1:0]     root_cnt, exp_deg;
  logic           sig_fail;

  logic [M-1:0]   s1_alpha, s3_alpha3, s1_sq, s1_cube, acc_p, p_sq, s3c, sigma2, t1_nx, t2_nx;
  logic [M-1:0]   bit_gf;
  logic [N-1:0]   buffer_nx;
  logic [1:0]     root_nx;
  logic           word_fail;

  assign bit_gf = {{(M-1){1'b0}}, in_bit};
  assign s3c    = s3 ^ c;

  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_s1a  (.a(s1),     .b(ALPHA),      .p(s1_alpha));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_s3a  (.a(s3),     .b(ALPHA3),     .p(s3_alpha3));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_sq   (.a(s1),     .b(s1),         .p(s1_sq));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_cube (.a(s1_sq),  .b(s1),         .p(s1_cube));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_accp (.a(acc),    .b(p),          .p(acc_p));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_psq  (.a(p),      .b(p),          .p(p_sq));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_sig2 (.a(s3c),    .b(acc),        .p(sigma2));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_t1   (.a(t1),     .b(ALPHA_INV),  .p(t1_nx));
  bch_gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_t2   (.a(t2),     .b(ALPHA_INV2), .p(t2_nx));

  // Chien step outcome: locator zero test, corrected buffer, root count and final verdict.
  always_comb begin
    buffer_nx = buffer;
    root_nx   = root_cnt;
    if (!sig_fail && ((GF_ONE ^ t1 ^ t2) == GF_ZERO)) begin
      buffer_nx = buffer ^ (N_ONE << step);
      root_nx   = (root_cnt == 2'd3) ? root_cnt : root_cnt + 2'd1;
    end else begin
      buffer_nx = buffer;
      root_nx   = root_cnt;
    end
    word_fail = sig_fail || (root_nx != exp_deg);
  end

  // Decoder FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RX;
      buffer      <= {N{1'b0}};
      raw_msg     <= {K{1'b0}};
      s1          <= GF_ZERO;
      s3          <= GF_ZERO;
      c           <= GF_ZERO;
      acc         <= GF_ZERO;
      p           <= GF_ZERO;
      t1          <= GF_ZERO;
      t2          <= GF_ZERO;
      bit_cnt     <= {CW{1'b0}};
      step        <= {M{1'b0}};
      root_cnt    <= 2'd0;
      exp_deg     <= 2'd0;
      sig_fail    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_msg     <= {K{1'b0}};
      out_err_cnt <= 2'd0;
      out_fail    <= 1'b0;
    end else begin
      case (state)
        ST_RX: begin
          if (in_valid) begin
            buffer  <= {buffer[N-2:0], in_bit};
            s1      <= s1_alpha ^ bit_gf;
            s3      <= s3_alpha3 ^ bit_gf;
            bit_cnt <= bit_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (bit_cnt == CW'(N - 1)) begin
              state    <= ST_CUBE;
              in_ready <= 1'b0;
            end
          end
        end
        ST_CUBE: begin
          // p starts at S1^2 so M-1 accumulations give S1^(2+4+...+2^(M-1)) = S1^-1.
          c        <= s1_cube;
          p        <= s1_sq;
          acc      <= GF_ONE;
          raw_msg  <= buffer[N-1:N-K];
          root_cnt <= 2'd0;
          step     <= {M{1'b0}};
          state    <= ST_INV;
        end
        ST_INV: begin
          acc <= acc_p;
          p   <= p_sq;
          if (step == M'(M - 2)) begin
            step  <= {M{1'b0}};
            state <= ST_SIGMA;
          end else begin
            step <= step + {{(M-1){1'b0}}, 1'b1};
          end
        end
        ST_SIGMA: begin
          t1 <= s1;
          t2 <= sigma2;
          if (s1 == GF_ZERO) begin
            exp_deg  <= 2'd0;
            sig_fail <= (s3 != GF_ZERO);
          end else if (s3 == c) begin
            exp_deg  <= 2'd1;
            sig_fail <= 1'b0;
          end else begin
            exp_deg  <= 2'd2;
            sig_fail <= 1'b0;
          end
          step  <= {M{1'b0}};
          state <= ST_CHIEN;
        end
        ST_CHIEN: begin
          buffer   <= buffer_nx;
          root_cnt <= root_nx;
          t1       <= t1_nx;
          t2       <= t2_nx;
          if (step == M'(N - 1)) begin
            state       <= ST_DONE;
            out_valid   <= 1'b1;
            out_fail    <= word_fail;
            out_msg     <= word_fail ? raw_msg : buffer_nx[N-1:N-K];
            out_err_cnt <= word_fail ? 2'd0 : root_nx;
          end else begin
            step <= step + {{(M-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_RX;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            s1        <= GF_ZERO;
            s3        <= GF_ZERO;
            bit_cnt   <= {CW{1'b0}};
          end
        end
        default: begin
          state     <= ST_RX;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_serial_decoder.sv
// Self-checking bench for bch_serial_decoder (M=4, BCH(15,7)).
module tb_bch_serial_decoder;

  localparam int K = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_msg;
  logic [1:0]   out_err_cnt;
  logic         out_fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bch_serial_decoder #(.M(4), .PRIM_POLY(5'b10011), .K(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_err_cnt(out_err_cnt), .out_fail(out_fail)
  );

  typedef struct {
    logic [14:0] cw;
    logic [6:0]  msg;
    logic [1:0]  cnt;
    logic        fail;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Systematic encoder: message at degrees 14..8, remainder mod g(x)=x^8+x^7+x^6+x^4+1 below.
  function automatic logic [14:0] encode(input logic [6:0] msg);
    logic [14:0] r;
    r = {msg, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (15'h01D1 << (i - 8));
    return {msg, r[7:0]};
  endfunction

  // Bounded-distance decoding by exhaustive search over the 128 codewords.
  task automatic model_decode(input logic [14:0] rx, output logic [6:0] msg,
                              output logic [1:0] cnt, output logic fail);
    msg  = rx[14:8];
    cnt  = 2'd0;
    fail = 1'b1;
    for (int m = 0; m < 128; m++) begin
      int d;
      d = $countones(encode(7'(m)) ^ rx);
      if (d <= 2) begin
        msg  = 7'(m);
        cnt  = 2'(d);
        fail = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int guard;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_bit   = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [14:0] cw, input bit gaps);
    for (int i = 14; i >= 0; i--)
      send_bit(cw[i], gaps && ($urandom_range(0, 3) == 0));
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [14:0] cw, input logic [6:0] msg,
                          input logic [1:0] cnt, input logic fail, input bit gaps, input bit chk_lat);
    int lat;
    send_word(cw, gaps);
    wait_out(lat);
    if (chk_lat) check({name, "_latency"}, 32'(lat), 32'd20);
    check({name, "_msg"},  32'(out_msg),     32'(msg));
    check({name, "_cnt"},  32'(out_err_cnt), 32'(cnt));
    check({name, "_fail"}, 32'(out_fail),    32'(fail));
    take_out();
    check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  vec_t        vecs[4];
  logic [14:0] cw, err;
  logic [6:0]  m_msg;
  logic [1:0]  m_cnt;
  logic        m_fail;
  int          lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_out_msg",   32'(out_msg),     32'd0);
    check("rst_err_cnt",   32'(out_err_cnt), 32'd0);
    check("rst_fail",      32'(out_fail),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{15'h01D1, 7'h01, 2'd0, 1'b0};
    vecs[1] = '{15'h41D1, 7'h01, 2'd1, 1'b0};
    vecs[2] = '{15'h41D0, 7'h01, 2'd2, 1'b0};
    vecs[3] = '{15'h7000, 7'h74, 2'd2, 1'b0};
    for (int i = 0; i < 4; i++)
      run_word($sformatf("vec%0d", i), vecs[i].cw, vecs[i].msg, vecs[i].cnt, vecs[i].fail, 1'b0, 1'b1);

    // Random words with 0..3 errors and random in_valid gaps, against the search model.
    for (int i = 0; i < 40; i++) begin
      int nerr;
      nerr = $urandom_range(0, 3);
      err  = 15'd0;
      while ($countones(err) < nerr) err = err | (15'd1 << $urandom_range(0, 14));
      cw = encode(7'($urandom)) ^ err;
      model_decode(cw, m_msg, m_cnt, m_fail);
      run_word($sformatf("rand%0d", i), cw, m_msg, m_cnt, m_fail, 1'b1, 1'b1);
    end

    // Backpressure: result held for 10 cycles while stray input is offered, then a second word.
    cw = encode(7'h5A) ^ 15'h0100;
    model_decode(cw, m_msg, m_cnt, m_fail);
    send_word(cw, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_msg",       32'(out_msg),   32'(m_msg));
      check("stall_cnt",       32'(out_err_cnt), 32'(m_cnt));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take_out();
    check("stall_in_ready_after", 32'(in_ready), 32'd1);
    cw = encode(7'h33) ^ 15'h2004;
    model_decode(cw, m_msg, m_cnt, m_fail);
    run_word("b2b_second", cw, m_msg, m_cnt, m_fail, 1'b1, 1'b0);

    // Reset during the Chien search discards the word; the following word decodes.
    send_word(encode(7'h2B) ^ 15'h0010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready",  32'(in_ready),    32'd1);
    check("midrst_out_valid", 32'(out_valid),   32'd0);
    check("midrst_out_msg",   32'(out_msg),     32'd0);
    check("midrst_err_cnt",   32'(out_err_cnt), 32'd0);
    check("midrst_fail",      32'(out_fail),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cw = encode(7'h6C) ^ 15'h0801;
    model_decode(cw, m_msg, m_cnt, m_fail);
    run_word("after_rst", cw, m_msg, m_cnt, m_fail, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
